// File: rtl/banked_register_file.sv
// ---------------------------------------------------------------------------
// banked_register_file
//
// Multi-ported register file with write-to-read bypass, optional hardwired
// zero entry and a self-initialising zero sweep. After reset or a clear
// request, the block spends DEPTH cycles writing zero to every entry. During
// that time ready is low, writes are dropped and reads return zero.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst_n           : asynchronous active-low reset (restarts the zero sweep)
//   clear           : single-cycle request to re-zero every entry
//   ready           : high while the file accepts writes (sweep finished)
//   we              : per-write-port strobe
//   write_addr      : per-write-port address
//   write_data      : per-write-port data
//   read_addr       : per-read-port address
//   read_data       : per-read-port data (combinational)
//   write_collision : one-cycle pulse; two or more live write ports hit one
//                     address on the previous cycle
//   zero_write      : one-cycle pulse; a write to address 0 was discarded on
//                     the previous cycle (ZERO_HARDWIRED only)
// ---------------------------------------------------------------------------
module banked_register_file #(
   parameter int DATA_WIDTH      = 32,
   parameter int DEPTH           = 64,
   parameter int NUM_READ_PORTS  = 2,
   parameter int NUM_WRITE_PORTS = 2,
   parameter bit BYPASS          = 1'b1,
   parameter bit ZERO_HARDWIRED  = 1'b1,
   localparam int ADDR_W         = $clog2(DEPTH)
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        clear,
   output logic                                        ready,
   input  logic [NUM_WRITE_PORTS-1:0]                  we,
   input  logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0]      write_addr,
   input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  write_data,
   input  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0]       read_addr,
   output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]   read_data,
   output logic                                        write_collision,
   output logic                                        zero_write
);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t                      state_q, state_d;
   logic [ADDR_W-1:0]           init_count_q, init_count_d;
   logic                        write_collision_q, write_collision_d;
   logic                        zero_write_q, zero_write_d;
   logic [DATA_WIDTH-1:0]       mem_q [DEPTH];

   logic                        accept;
   logic [NUM_WRITE_PORTS-1:0]  wr_en;
   logic                        zero_hit;
   logic                        collision;

   assign ready           = (state_q == ST_READY);
   assign write_collision = write_collision_q;
   assign zero_write      = zero_write_q;

   // Qualify each write port. A write is live only in READY and not in a
   // clear cycle; with a hardwired zero entry, writes to address 0 are
   // dropped here so they neither update storage, bypass, nor count as
   // colliding.
   always_comb begin
      accept    = (state_q == ST_READY) && !clear;
      wr_en     = '0;
      zero_hit  = 1'b0;
      collision = 1'b0;
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
         if (accept && we[p]) begin
            if (ZERO_HARDWIRED && (write_addr[p] == '0)) begin
               zero_hit = 1'b1;
            end else begin
               wr_en[p] = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
         for (int j = i + 1; j < NUM_WRITE_PORTS; j++) begin
            if (wr_en[i] && wr_en[j] && (write_addr[i] == write_addr[j])) begin
               collision = 1'b1;
            end
         end
      end
   end

   // Next-state logic for the INIT/READY controller and the status pulses.
   // The counter holds at DEPTH-1 on leaving INIT rather than wrapping.
   always_comb begin
      state_d           = state_q;
      init_count_d      = init_count_q;
      write_collision_d = collision;
      zero_write_d      = zero_hit;
      case (state_q)
         ST_INIT: begin
            if (clear) begin
               init_count_d = '0;
            end else if (init_count_q == LAST_ADDR) begin
               state_d = ST_READY;
            end else begin
               init_count_d = init_count_q + 1'b1;
            end
         end
         ST_READY: begin
            if (clear) begin
               state_d      = ST_INIT;
               init_count_d = '0;
            end
         end
         default: begin
            state_d      = ST_INIT;
            init_count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= ST_INIT;
         init_count_q      <= '0;
         write_collision_q <= 1'b0;
         zero_write_q      <= 1'b0;
      end else begin
         state_q           <= state_d;
         init_count_q      <= init_count_d;
         write_collision_q <= write_collision_d;
         zero_write_q      <= zero_write_d;
      end
   end

   // Storage has no reset; the INIT sweep zeroes it. Sweep writes and port
   // writes are mutually exclusive because wr_en requires READY. Ports are
   // applied in ascending order so the highest-indexed port wins a collision.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem_q[init_count_q] <= '0;
      end
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
         if (wr_en[p]) begin
            mem_q[write_addr[p]] <= write_data[p];
         end
      end
   end

   // Read path: array contents, overridden by the highest-indexed live write
   // to the same address when bypassing, then forced to zero for address 0
   // (hardwired) or while not ready.
   always_comb begin
      read_data = '0;
      for (int r = 0; r < NUM_READ_PORTS; r++) begin
         if (ready) begin
            read_data[r] = mem_q[read_addr[r]];
            if (BYPASS) begin
               for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                  if (wr_en[p] && (write_addr[p] == read_addr[r])) begin
                     read_data[r] = write_data[p];
                  end
               end
            end
            if (ZERO_HARDWIRED && (read_addr[r] == '0)) begin
               read_data[r] = '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_banked_register_file.sv
// ---------------------------------------------------------------------------
// tb_banked_register_file
//
// Directed bench for banked_register_file with default parameters
// (32-bit x 64 entries, 2 read ports, 2 write ports, bypass, hardwired zero).
// Inputs change 1 time unit after the rising edge; outputs are checked
// mid-cycle.
// ---------------------------------------------------------------------------
module tb_banked_register_file;

   localparam int DW = 32;
   localparam int DEPTH = 64;
   localparam int AW = 6;

   logic                  clk;
   logic                  rst_n;
   logic                  clear;
   logic                  ready;
   logic [1:0]            we;
   logic [1:0][AW-1:0]    write_addr;
   logic [1:0][DW-1:0]    write_data;
   logic [1:0][AW-1:0]    read_addr;
   logic [1:0][DW-1:0]    read_data;
   logic                  write_collision;
   logic                  zero_write;

   int total;
   int bad;
   int cyc;

   banked_register_file dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear           (clear),
      .ready           (ready),
      .we              (we),
      .write_addr      (write_addr),
      .write_data      (write_data),
      .read_addr       (read_addr),
      .read_data       (read_data),
      .write_collision (write_collision),
      .zero_write      (zero_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges until ready rises, bounded; returns the edge count.
   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic idle_inputs();
      clear      = 1'b0;
      we         = '0;
      write_addr = '0;
      write_data = '0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         read_addr[0] = AW'(a);
         read_addr[1] = AW'(DEPTH - 1 - a);
         #1;
         chk({tag, "_p0"}, 64'(read_data[0]), 64'h0);
         chk({tag, "_p1"}, 64'(read_data[1]), 64'h0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      read_addr = '0;
      idle_inputs();

      // Reset state
      repeat (3) tick();
      chk("rst_ready", 64'(ready), 64'h0);
      chk("rst_coll", 64'(write_collision), 64'h0);
      chk("rst_zw", 64'(zero_write), 64'h0);

      // Initial sweep: exactly DEPTH cycles, then all entries read 0
      rst_n = 1'b1;
      wait_ready(cyc);
      chk("init_len", 64'(cyc), 64'd64);
      check_all_zero("init_zero");

      // Write addr 5 on port 0: same-cycle bypass on both read ports, then array
      we[0] = 1'b1;
      write_addr[0] = 6'd5;
      write_data[0] = 32'hDEADBEEF;
      read_addr[0] = 6'd5;
      read_addr[1] = 6'd5;
      #1;
      chk("byp_p0", 64'(read_data[0]), 64'hDEADBEEF);
      chk("byp_p1", 64'(read_data[1]), 64'hDEADBEEF);
      tick();
      idle_inputs();
      #1;
      chk("arr5", 64'(read_data[0]), 64'hDEADBEEF);
      chk("wr5_coll", 64'(write_collision), 64'h0);
      chk("wr5_zw", 64'(zero_write), 64'h0);

      // Collision on addr 9: port 1 wins, one-cycle flag
      we = 2'b11;
      write_addr[0] = 6'd9;
      write_data[0] = 32'h1;
      write_addr[1] = 6'd9;
      write_data[1] = 32'h2;
      read_addr[0] = 6'd9;
      #1;
      chk("coll_byp", 64'(read_data[0]), 64'h2);
      tick();
      idle_inputs();
      #1;
      chk("coll_flag", 64'(write_collision), 64'h1);
      chk("coll_data", 64'(read_data[0]), 64'h2);
      tick();
      chk("coll_pulse", 64'(write_collision), 64'h0);

      // Write to addr 0: discarded, zero_write pulse, no collision
      we[0] = 1'b1;
      write_addr[0] = 6'd0;
      write_data[0] = 32'hFFFFFFFF;
      read_addr[0] = 6'd0;
      #1;
      chk("zero_byp", 64'(read_data[0]), 64'h0);
      tick();
      idle_inputs();
      #1;
      chk("zero_flag", 64'(zero_write), 64'h1);
      chk("zero_coll", 64'(write_collision), 64'h0);
      chk("zero_rd", 64'(read_data[0]), 64'h0);
      tick();
      chk("zero_pulse", 64'(zero_write), 64'h0);

      // Both ports hit address 0: zero_write only, not a collision
      we = 2'b11;
      write_addr[0] = 6'd0;
      write_addr[1] = 6'd0;
      write_data[0] = 32'h11;
      write_data[1] = 32'h22;
      tick();
      idle_inputs();
      chk("z2_flag", 64'(zero_write), 64'h1);
      chk("z2_coll", 64'(write_collision), 64'h0);

      // Fill addr 1..63 (two ports per cycle where possible)
      for (int a = 1; a < DEPTH; a += 2) begin
         we[0] = 1'b1;
         write_addr[0] = AW'(a);
         write_data[0] = 32'h100 + 32'(a);
         we[1] = (a + 1 < DEPTH);
         write_addr[1] = AW'(a + 1);
         write_data[1] = 32'h100 + 32'(a + 1);
         tick();
      end
      idle_inputs();
      read_addr[0] = 6'd1;
      read_addr[1] = 6'd63;
      #1;
      chk("fill1", 64'(read_data[0]), 64'h101);
      chk("fill63", 64'(read_data[1]), 64'h13F);
      read_addr[0] = 6'd40;
      #1;
      chk("fill40", 64'(read_data[0]), 64'h128);

      // Clear with a simultaneous write (discarded); writes during sweep ignored
      clear = 1'b1;
      we[0] = 1'b1;
      write_addr[0] = 6'd3;
      write_data[0] = 32'hCAFE0003;
      tick();
      clear = 1'b0;
      chk("clr_ready", 64'(ready), 64'h0);
      cyc = 0;
      while (!ready && cyc < 200) begin
         we[0] = 1'b1;
         write_addr[0] = 6'd7;
         write_data[0] = 32'hAAAA5555;
         read_addr[0] = 6'd7;
         #1;
         if (cyc == 10) chk("sweep_rd", 64'(read_data[0]), 64'h0);
         tick();
         cyc++;
      end
      idle_inputs();
      chk("clr_len", 64'(cyc), 64'd64);
      check_all_zero("clr_zero");

      // Reset at cycle 30 of INIT aborts the sweep; full sweep after release
      we[0] = 1'b1;
      write_addr[0] = 6'd40;
      write_data[0] = 32'h12345678;
      tick();
      idle_inputs();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (30) tick();
      rst_n = 1'b0;
      #1;
      chk("arst_ready", 64'(ready), 64'h0);
      repeat (3) tick();
      chk("arst_hold", 64'(ready), 64'h0);
      rst_n = 1'b1;
      wait_ready(cyc);
      chk("arst_len", 64'(cyc), 64'd64);
      read_addr[0] = 6'd40;
      #1;
      chk("arst_rd40", 64'(read_data[0]), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/banked_register_file.md
BANKED_REGISTER_FILE -- requirements
Module: banked_register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of each entry in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning the entry count, a power of two, minimum 4; ADDR_W = log2(DEPTH).
REQ-003 The block SHALL have parameter NUM_READ_PORTS, default 2, meaning the number of independent read ports, range 1..4.
REQ-004 The block SHALL have parameter NUM_WRITE_PORTS, default 2, meaning the number of independent write ports, range 1..3.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning that when 1, same-cycle write data is forwarded to reads.
REQ-006 The block SHALL have parameter ZERO_HARDWIRED, default 1, meaning that when 1, address 0 always reads 0 and is never written.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port clear, input, 1 bit: single-cycle request to re-zero all entries.
REQ-010 The block SHALL have port ready, output, 1 bit: high when initialisation is complete and writes are accepted.
REQ-011 The block SHALL have ports we / write_addr / write_data, input, NUM_WRITE_PORTS x {1, ADDR_W, DATA_WIDTH}: the per-port write strobe, address and data.
REQ-012 The block SHALL have ports read_addr, input, NUM_READ_PORTS x ADDR_W, and read_data, output, NUM_READ_PORTS x DATA_WIDTH: the per-port read address and data.
REQ-013 The block SHALL have port write_collision, output, 1 bit: registered pulse flagging that two or more enabled write ports targeted one address in the previous cycle.
REQ-014 The block SHALL have port zero_write, output, 1 bit: registered pulse flagging a discarded write to address 0 in the previous cycle (ZERO_HARDWIRED=1 only, else tied 0).

Function
REQ-015 The block SHALL implement a two-state FSM, INIT and READY, with a ADDR_W-bit init counter.
REQ-016 In INIT the block SHALL write 0 to entry init_count each cycle, increment the counter, and move to READY on the cycle entry DEPTH-1 is written; INIT lasts exactly DEPTH cycles.
REQ-017 In READY, clear=1 SHALL move the FSM to INIT with init_count=0 on the next edge; clear in INIT SHALL restart the counter at 0.
REQ-018 ready SHALL be high exactly in READY.
REQ-019 Writes with ready=0 SHALL be discarded without flags.
REQ-020 In READY, each port with we=1 SHALL update entry write_addr at the clock edge; latency is 1 cycle to array visibility.
REQ-021 On address collision between enabled write ports, the highest-indexed port SHALL win, and write_collision SHALL pulse for one cycle.
REQ-022 A write in the same cycle as clear SHALL be discarded.
REQ-023 read_data SHALL be combinational from read_addr: the highest-indexed enabled matching write port's data if BYPASS=1 and ready=1, else the array contents.
REQ-024 With ZERO_HARDWIRED=1, read_addr=0 SHALL return 0 regardless of bypass, and writes to 0 SHALL be discarded and raise zero_write for one cycle; a port writing address 0 SHALL NOT count toward write_collision.
REQ-025 With ready=0, all read_data SHALL be 0.
REQ-026 Address arithmetic SHALL be unsigned ADDR_W bits; the init counter SHALL NOT wrap past DEPTH-1.

Reset
REQ-027 rst_n=0 SHALL asynchronously force the FSM to INIT, init_count=0, ready=0, write_collision=0 and zero_write=0.
REQ-028 The storage array SHALL NOT be reset directly; it is zeroed by the INIT sweep after rst_n deasserts.
REQ-029 Reset asserted mid-INIT or mid-write SHALL abort the operation, and the full DEPTH-cycle sweep SHALL restart after release.

Verification
REQ-030 The bench SHALL cover: release rst_n -> ready=0 for exactly 64 cycles, then 1, and every address reads 0.
REQ-031 The bench SHALL cover: ready, port0 writes addr 5 = 0xDEADBEEF -> same-cycle read of addr 5 returns 0xDEADBEEF (BYPASS=1) and next-cycle read returns 0xDEADBEEF.
REQ-032 The bench SHALL cover: port0 writes addr 9 = 0x1 and port1 writes addr 9 = 0x2 in one cycle -> addr 9 = 0x2 and write_collision=1 for one cycle.
REQ-033 The bench SHALL cover: write addr 0 = 0xFFFFFFFF -> zero_write=1 for one cycle, read addr 0 = 0, write_collision=0.
REQ-034 The bench SHALL cover: fill addr 1..63, pulse clear -> ready=0 for 64 cycles, writes during the sweep are ignored, then all reads return 0.
REQ-035 The bench SHALL cover: assert rst_n=0 at cycle 30 of INIT -> ready stays 0, and 64 cycles after release ready=1.
